// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between the fetch port and the data port, data first.
module mem_port_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic                f_flush,
  output logic                f_valid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_we,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  localparam int SK_W = $clog2(MAX_STREAK + 1);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GNT_F,
    GNT_D,
    RESP
  } state_t;

  state_t          state;
  logic [SK_W-1:0] streak;
  logic [WD_W-1:0] wdog;
  logic            flush_pend;

  logic f_starved;
  logic grant_d;
  logic grant_f;
  logic wd_hit;
  logic flush_now;

  assign f_starved = f_req && (streak == SK_W'(MAX_STREAK));
  assign grant_d   = d_req && !f_starved;
  assign grant_f   = !grant_d && f_req && !f_flush;
  assign wd_hit    = (TIMEOUT != 0) &&
                     (wdog == WD_W'(TIMEOUT - 1));
  // a flush arriving in the ack cycle still squashes the response
  assign flush_now = flush_pend || f_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak     <= '0;
      wdog       <= '0;
      flush_pend <= 1'b0;
      f_valid    <= 1'b0;
      f_rdata    <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      m_req      <= 1'b0;
      m_addr     <= '0;
      m_we       <= '0;
      m_wdata    <= '0;
      err        <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (grant_d) begin
            state   <= GNT_D;
            m_req   <= 1'b1;
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
            if (!f_req)
              streak <= '0;
            else if (streak != SK_W'(MAX_STREAK))
              streak <= streak + SK_W'(1);
          end else if (grant_f) begin
            state   <= GNT_F;
            m_req   <= 1'b1;
            m_addr  <= f_addr;
            m_we    <= '0;
            m_wdata <= '0;
            streak  <= '0;
          end else if (!f_req) begin
            streak <= '0;
          end
        end
        GNT_F, GNT_D: begin
          if (state == GNT_F)
            flush_pend <= flush_now;
          if (m_ack || wd_hit) begin
            m_req <= 1'b0;
            state <= RESP;
            if (!m_ack)
              err <= 1'b1;
            if (state == GNT_D) begin
              d_rdata <= m_ack ? m_rdata : '0;
              d_valid <= 1'b1;
            end else if (!flush_now) begin
              f_rdata <= m_ack ? m_rdata : '0;
              f_valid <= 1'b1;
            end
          end else if (TIMEOUT != 0) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences
// for streak, flush, watchdog and async reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_flush, f_valid;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_we, m_we;
  logic        m_req, m_ack, err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mem_rdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mwe;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs[4];

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_STREAK(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f_req(f_req),
    .f_addr(f_addr),
    .f_flush(f_flush),
    .f_valid(f_valid),
    .f_rdata(f_rdata),
    .d_req(d_req),
    .d_addr(d_addr),
    .d_we(d_we),
    .d_wdata(d_wdata),
    .d_valid(d_valid),
    .d_rdata(d_rdata),
    .m_req(m_req),
    .m_addr(m_addr),
    .m_we(m_we),
    .m_wdata(m_wdata),
    .m_ack(m_ack),
    .m_rdata(m_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    bit hold_ok;
    bit quiet_ok;
    if (v.is_d) begin
      d_req   = 1'b1;
      d_addr  = v.addr;
      d_we    = v.we;
      d_wdata = v.wdata;
    end else begin
      f_req  = 1'b1;
      f_addr = v.addr;
    end
    step();
    chk({tag, ".m_req_issue"}, 32'(m_req), 32'd1);
    chk({tag, ".m_addr"}, m_addr, v.addr);
    chk({tag, ".m_we"}, 32'(m_we), 32'(v.exp_mwe));
    chk({tag, ".m_wdata"}, m_wdata, v.exp_mwdata);
    hold_ok  = 1'b1;
    quiet_ok = 1'b1;
    for (int k = 1; k <= v.lat; k++) begin
      if (!m_req) hold_ok = 1'b0;
      if (f_valid || d_valid) quiet_ok = 1'b0;
      if (k == v.lat) begin
        m_ack   = 1'b1;
        m_rdata = v.mem_rdata;
      end
      step();
      m_ack   = 1'b0;
      m_rdata = 32'h0;
    end
    chk({tag, ".m_req_hold"}, 32'(hold_ok), 32'd1);
    chk({tag, ".no_early_valid"}, 32'(quiet_ok), 32'd1);
    chk({tag, ".m_req_drop"}, 32'(m_req), 32'd0);
    if (v.is_d) begin
      chk({tag, ".d_valid"}, 32'(d_valid), 32'd1);
      chk({tag, ".f_valid_off"}, 32'(f_valid), 32'd0);
      chk({tag, ".d_rdata"}, d_rdata, v.exp_rdata);
    end else begin
      chk({tag, ".f_valid"}, 32'(f_valid), 32'd1);
      chk({tag, ".d_valid_off"}, 32'(d_valid), 32'd0);
      chk({tag, ".f_rdata"}, f_rdata, v.exp_rdata);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    step();
    chk({tag, ".pulse_end"}, 32'(f_valid | d_valid), 32'd0);
    chk({tag, ".idle_m_req"}, 32'(m_req), 32'd0);
  endtask

  initial begin
    bit   grants[10];
    bit   exp_grants[10];
    bit   prev;
    bit   fv;
    int   ngr;
    int   cnt;
    vec_t v;

    vecs[0] = '{1'b0, 32'h100, 4'h0, 32'h0, 2,
                32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h40, 4'b0011, 32'h12345678, 1,
                32'h55AA55AA, 32'h55AA55AA, 4'b0011, 32'h12345678};
    vecs[2] = '{1'b0, 32'h104, 4'h0, 32'h0, 1,
                32'h00000013, 32'h00000013, 4'h0, 32'h0};
    vecs[3] = '{1'b1, 32'h44, 4'h0, 32'h0, 3,
                32'hCAFEF00D, 32'hCAFEF00D, 4'h0, 32'h0};
    exp_grants = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    f_req = 0; f_addr = 0; f_flush = 0;
    d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0;
    m_ack = 0; m_rdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst.m_req", 32'(m_req), 32'd0);
    chk("rst.valids", 32'(f_valid | d_valid), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.m_addr", m_addr, 32'h0);
    chk("rst.rdata", f_rdata | d_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++)
      do_txn(vecs[i], $sformatf("vec%0d", i));

    // both ports requesting continuously
    f_req = 1'b1; f_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 4'h0; d_wdata = 32'h0;
    ngr = 0;
    prev = 1'b0;
    for (int c = 0; c < 80 && ngr < 10; c++) begin
      if (m_req && !prev) begin
        grants[ngr] = (m_addr == 32'h300);
        ngr++;
      end
      prev    = m_req;
      m_ack   = m_req;
      m_rdata = m_addr + 32'h1;
      step();
    end
    m_ack = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    chk("prio.count", 32'(ngr), 32'd10);
    for (int i = 0; i < ngr; i++)
      chk($sformatf("prio.grant%0d_is_d", i),
          32'(grants[i]), 32'(exp_grants[i]));
    step();
    step();
    chk("prio.f_rdata", f_rdata, 32'h201);

    // flush while fetch is in flight
    f_req = 1'b1; f_addr = 32'h180;
    step();
    chk("flush.m_req", 32'(m_req), 32'd1);
    f_flush = 1'b1;
    f_req = 1'b0;
    fv = f_valid;
    step();
    f_flush = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      if (f_valid || !m_req) fv = 1'b1;
      if (k == 4) begin
        m_ack = 1'b1;
        m_rdata = 32'h99999999;
      end
      step();
      m_ack = 1'b0;
    end
    chk("flush.in_flight", 32'(fv), 32'd0);
    chk("flush.m_req_drop", 32'(m_req), 32'd0);
    chk("flush.f_valid", 32'(f_valid), 32'd0);
    chk("flush.f_rdata", f_rdata, 32'h201);
    step();
    chk("flush.f_valid_late", 32'(f_valid), 32'd0);

    f_req = 1'b1; f_flush = 1'b1; f_addr = 32'h1C0;
    step();
    chk("flush.idle_block", 32'(m_req), 32'd0);
    f_req = 1'b0; f_flush = 1'b0;
    step();
    chk("flush.idle_quiet", 32'(m_req), 32'd0);
    v = '{1'b1, 32'h48, 4'h0, 32'h0, 1,
          32'h0F0F0F0F, 32'h0F0F0F0F, 4'h0, 32'h0};
    do_txn(v, "after_flush");

    // watchdog: no ack ever
    d_req = 1'b1; d_addr = 32'h50; d_we = 4'h0; d_wdata = 32'h0;
    step();
    cnt = 0;
    while (m_req && cnt < 20) begin
      cnt++;
      step();
    end
    chk("tmo.m_req_cycles", 32'(cnt), 32'd8);
    chk("tmo.d_valid", 32'(d_valid), 32'd1);
    chk("tmo.d_rdata", d_rdata, 32'h0);
    chk("tmo.err", 32'(err), 32'd1);
    d_req = 1'b0;
    step();
    v = '{1'b0, 32'h108, 4'h0, 32'h0, 2,
          32'h00A00093, 32'h00A00093, 4'h0, 32'h0};
    do_txn(v, "post_tmo");
    chk("tmo.err_sticky", 32'(err), 32'd1);

    // async reset in the middle of a data grant
    d_req = 1'b1; d_addr = 32'h60; d_we = 4'hF; d_wdata = 32'h0BADF00D;
    step();
    chk("arst.granted", 32'(m_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.m_req", 32'(m_req), 32'd0);
    chk("arst.err", 32'(err), 32'd0);
    chk("arst.d_valid", 32'(d_valid), 32'd0);
    d_req = 1'b0;
    step();
    chk("arst.d_valid_hold", 32'(d_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("arst.idle", 32'(m_req | d_valid | f_valid), 32'd0);
    v = '{1'b0, 32'h10C, 4'h0, 32'h0, 1,
          32'h12300513, 32'h12300513, 4'h0, 32'h0};
    do_txn(v, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the CPU's instruction-fetch port (read-only) and its data port (read/write, byte enables).
- Sits between the pipeline's fetch/memory-stage ports and the backing memory.
- Data accesses have priority, bounded by an anti-starvation streak limit.
- Supports fetch flush on branch/halt, and a watchdog timeout on the memory handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_STREAK, 4, maximum consecutive data grants while a fetch request waits.
- TIMEOUT, 255, cycles to wait for m_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; held with f_addr stable until f_valid or f_flush
- f_addr  in  ADDR_W  fetch address
- f_flush  in  1  cancel the outstanding/pending fetch (branch or halt)
- f_valid  out  1  one-cycle pulse; f_rdata valid
- f_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request; held with d_addr/d_we/d_wdata stable until d_valid
- d_addr  in  ADDR_W  data address
- d_we  in  DATA_W/8  byte write enables; 0 means read
- d_wdata  in  DATA_W  store data
- d_valid  out  1  one-cycle pulse; access complete, d_rdata valid for reads
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request, held until m_ack
- m_addr  out  ADDR_W  memory address
- m_we  out  DATA_W/8  memory byte enables
- m_wdata  out  DATA_W  memory write data
- m_ack  in  1  memory completion, one cycle; m_rdata valid the same cycle
- m_rdata  in  DATA_W  memory read data
- err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0.
  - state IDLE, streak 0, watchdog 0, flush-pending 0.
  - Reset mid-transaction drops m_req immediately; no valid pulse is produced.
- States: IDLE, GNT_F, GNT_D, RESP.
- IDLE, grant selection:
  - d_req and not (f_req and streak==MAX_STREAK): grant D.
  - else f_req and not f_flush: grant F.
  - On grant, register m_addr/m_we/m_wdata (F: m_we=0, m_wdata=0) and set m_req=1 the next cycle.
  - Issue latency from req to m_req is 1 cycle.
- Streak counter:
  - Increments on each D grant while f_req is high, saturating at MAX_STREAK.
  - Cleared on each F grant, and when f_req is low in IDLE.
- GNT_F/GNT_D:
  - m_req and the registered fields stay stable; the watchdog counts cycles.
  - On m_ack: m_req=0 and capture m_rdata into the granted port's rdata; go to RESP.
  - If the watchdog reaches TIMEOUT (nonzero) before m_ack: m_req=0, rdata=0, err=1 (sticky until reset); go to RESP.
- RESP:
  - Exactly one cycle. Pulse the granted port's valid, unless it is an F grant with flush-pending set.
  - No grant is made in RESP; the requester's still-high req this cycle is ignored. Return to IDLE.
  - Minimum per-access period: ack latency + 2 cycles.
- Flush:
  - f_flush during GNT_F sets flush-pending; the memory transaction still completes, f_valid is suppressed, and f_rdata is not updated.
  - f_flush in IDLE blocks an F grant that cycle.
  - f_flush is ignored for data transactions.
  - flush-pending clears on leaving RESP.
- Other rules:
  - rdata registers hold their last value between transactions.
  - f_valid and d_valid are never high in the same cycle.
  - m_ack outside GNT_* is ignored.
  - Simultaneous f_req and d_req with streak < MAX_STREAK: D wins.

Test Plan:
- Lone fetch: f_req=1, f_addr=0x100, memory acks 2 cycles after m_req with 0xDEADBEEF → m_req high 2 cycles, m_addr=0x100, m_we=0; f_valid one cycle later with f_rdata=0xDEADBEEF; d_valid stays 0.
- Store: d_req, d_addr=0x40, d_we=4'b0011, d_wdata=0x12345678, ack after 1 cycle → m_we=4'b0011, m_wdata=0x12345678; d_valid pulse; no f_valid.
- Priority and starvation (MAX_STREAK=4): f_req and d_req held continuously → grant order D,D,D,D,F,D,D,D,D,F; streak resets after each F.
- Flush: f_flush pulsed while in GNT_F with ack 3 cycles later → m_req completes normally; f_valid never asserts and f_rdata is unchanged; a following d_req is granted normally.
- Timeout (TIMEOUT=8): m_ack never asserted → m_req drops after 8 cycles; d_valid pulses with d_rdata=0; err=1 and stays 1 through later successful accesses.
- Async reset: rst_n low mid-GNT_D → m_req=0 immediately, no valid pulse, err=0; after release, a new f_req is served normally.
